// File: rtl/mul2k_scaler.sv
// Sequential modular scaler: y = x * 2^k mod Q, one modular doubling per cycle.
// Single transaction in flight, valid/ready on both the input and output side.
module mul2k_scaler #(
  parameter int unsigned Q  = 3329,
  parameter int unsigned W  = 12,
  parameter int unsigned KW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x,
  input  logic [KW-1:0] in_k,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_y
);

  localparam int unsigned W1 = W + 1;
  localparam logic [W1-1:0] Q_EXT = W1'(Q);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_acc;
  logic [KW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [W-1:0]  r_out_y;

  logic [W1-1:0] w_x_ext;
  logic [W-1:0]  w_red;
  logic [W1-1:0] w_dbl_t;
  logic [W-1:0]  w_dbl;

  // Input reduction: any W-bit value is below 2Q, so one conditional subtract lands in [0,Q).
  assign w_x_ext = {1'b0, in_x};
  assign w_red   = (w_x_ext >= Q_EXT) ? W'(w_x_ext - Q_EXT) : in_x;

  // Modular doubling on W+1 bits; with acc < Q the result again fits in [0,Q).
  assign w_dbl_t = {r_acc, 1'b0};
  assign w_dbl   = (w_dbl_t >= Q_EXT) ? W'(w_dbl_t - Q_EXT) : W'(w_dbl_t);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc      <= w_red;
            r_cnt      <= in_k;
            r_in_ready <= 1'b0;
            if (in_k == '0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out_y     <= w_red;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_acc <= w_dbl;
          r_cnt <= r_cnt - KW'(1);
          if (r_cnt == KW'(1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_y     <= w_dbl;
          end
        end
        S_DONE: begin
          // Result is held until taken; in_ready only returns the cycle after.
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;

endmodule

// File: tb/tb_mul2k_scaler.sv
// Randomized self-checking bench for mul2k_scaler against a cycle-level
// transaction model (pending job, due cycle, x*2^k mod Q).
module tb_mul2k_scaler;

  localparam int Q  = 3329;
  localparam int W  = 12;
  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_x = '0;
  logic [KW-1:0] in_k = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_y;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: one job at most, with its completion cycle and value.
  bit m_pend = 1'b0;
  int m_due  = 0;
  int m_y    = 0;

  mul2k_scaler #(.Q(Q), .W(W), .KW(KW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_k      (in_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int scale(input int x, input int k);
    return (x * (1 << k)) % Q;
  endfunction

  function automatic int half(input int a);
    return (a % 2 == 0) ? a / 2 : (a + Q) / 2;
  endfunction

  // Per-cycle compare against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      m_pend = 1'b0;
    end else begin
      chk("mon_in_ready", int'(in_ready), int'(!m_pend));
      chk("mon_out_valid", int'(out_valid), int'(m_pend && cyc >= m_due));
      if (out_valid && m_pend) chk("mon_out_y", int'(out_y), m_y);
      if (m_pend && cyc >= m_due && out_ready) begin
        m_pend = 1'b0;
      end else if (!m_pend && in_valid) begin
        m_pend = 1'b1;
        m_due  = cyc + int'(in_k) + 1;
        m_y    = scale(int'(in_x), int'(in_k));
      end
    end
  end

  task automatic send(input int x, input int k);
    bit ok;
    ok = 1'b0;
    in_x = W'(x);
    in_k = KW'(k);
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid after an accept; checks latency in cycles and the value.
  task automatic expect_out(input string name, input int exp, input int lat);
    int n;
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n = i;
        break;
      end
    end
    chk({name, "_lat"}, n, lat);
    chk({name, "_y"}, int'(out_y), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int x;
    int h;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_y", int'(out_y), 0);
    @(posedge clk);
    #1;

    // Directed operands with hand-computed results.
    send(1, 1);    expect_out("x1k1", 2, 2);
    send(1, 7);    expect_out("x1k7", 128, 8);
    send(1665, 1); expect_out("half_inv", 1, 2);
    send(3328, 3); expect_out("x3328k3", 3321, 4);
    send(0, 5);    expect_out("x0k5", 0, 6);
    send(4095, 0); expect_out("x4095k0", 766, 1);

    // Pre-halved inputs must come back to the original value.
    for (int k = 0; k < 8; k++) begin
      x = int'($urandom_range(0, Q - 1));
      h = x;
      for (int j = 0; j < k; j++) h = half(h);
      send(h, k);
      expect_out("inverse", x, k + 1);
    end

    // Backpressure: result must hold while out_ready is low; new input ignored.
    out_ready = 1'b0;
    send(3000, 2);
    expect_out("bp", 2013, 3);
    in_x = 12'd7;
    in_k = 3'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_y", int'(out_y), 2013);
      chk("bp_hold_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_rel_ready", int'(in_ready), 1);
    chk("bp_rel_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;

    // Reset in the middle of a long job.
    send(100, 7);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_ready", int'(in_ready), 1);
    chk("abort_y", int'(out_y), 0);
    @(posedge clk);
    #1;
    send(5, 2);
    expect_out("fresh", 20, 3);

    // Random stream with gaps; the monitor checks order, values and timing.
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 7)));
    end
    repeat (20) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul2k_scaler.md
Name: mul2k_scaler

Overview:
- Sequential modular scaler: computes y = x·2^k mod q for one coefficient per transaction.
- Performs one modular doubling per cycle.
- Inverse direction of the halving (x/2 mod q) step in the Gentleman-Sande/INTT butterfly path. Restores coefficients pre-scaled by 2^-k, and serves as a doubling reference in the polmul checker datapath.
- Sits between the coefficient memory read port and downstream consumers; valid/ready on both sides.

Parameters:
- Q, 3329, modulus; odd, Q < 2^W.
- W, 12, coefficient width.
- KW, 3, width of the shift-count field (k = 0..2^KW-1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  x/k presented.
- in_ready  output  1  block can accept (high only in IDLE).
- in_x  input  W  coefficient, any value 0..2^W-1.
- in_k  input  KW  number of doublings.
- out_valid  output  1  result held on out_y.
- out_ready  input  1  consumer accepts result.
- out_y  output  W  x·2^k mod Q, always in 0..Q-1.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_y=0, internal acc=0, cnt=0. Reset while BUSY/DONE discards the transaction; no output is produced for it.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid=1:
  - acc <= red(in_x), cnt <= in_k.
  - red(v) = v-Q if v >= Q, else v. One subtract suffices since 2^W-1 < 2Q.
  - next state = DONE if in_k==0, else BUSY.
- BUSY: in_ready=0, out_valid=0. Each edge:
  - acc <= dbl(acc), cnt <= cnt-1.
  - dbl(a) = t-Q if t >= Q, else t, where t = {a,1'b0} is W+1 bits.
  - When cnt==1, next state = DONE.
- DONE: out_valid=1, out_y=acc (registered, glitch-free). Holds stable until out_ready=1; then the next state is IDLE.
  - No accept in the same cycle as output handshake; in_ready returns the following cycle.
- Latency: accept edge at cycle 0 → out_valid high in cycle k+1 (k=0 → cycle 1).
- Occupancy/throughput: one transaction in flight; k+2 cycles per transaction with out_ready tied high.
- Arithmetic invariants:
  - acc < Q at every edge after accept.
  - Comparisons use W+1 bits; no wrap-around.
- Inputs in_x/in_k are sampled only at the accept edge. Changes while BUSY/DONE are ignored.
- out_ready while out_valid=0 has no effect.
- in_valid while in_ready=0 is not consumed; the upstream holds it.

Test Plan:
- Basic doubling: reset, then x=1, k=1 → out_y=2, out_valid in cycle 2 after accept; x=1, k=7 → 128 after 8 cycles.
- Wrap and inverse of halving: x=1665, k=1 → 1 (1665 = 1/2 mod 3329). Random x with k halvings applied by the golden model, then fed here → original x for all k in 0..7.
- Edge operands: x=3328, k=3 → 3321; x=0, k=5 → 0; x=4095, k=0 → 766 with out_valid one cycle after accept.
- Backpressure: x=3000, k=2 (→ 2013) with out_ready=0 for 10 cycles. Required: out_valid and out_y=2013 stable, in_ready=0, new in_valid ignored. Then out_ready=1 → IDLE next cycle and in_ready=1.
- Reset mid-operation: accept x=100, k=7, assert reset in cycle 3. Required: next cycle out_valid=0, in_ready=1, out_y=0. A fresh x=5, k=2 → 20 with no trace of the aborted job.
- Back-to-back stream of 1000 random (x,k) with out_ready tied high and random in_valid. Required: results match x·2^k mod 3329 in order, one transaction every k+2 cycles at full input rate.
